// File: rtl/ysyx_2022040010_axi_rw_pkg.sv
// rtl/ysyx_2022040010_axi_rw_pkg.sv - shared AXI codes and FSM encoding for the AXI read/write bridge
// Purpose: constants shared by the bridge and anything that decodes its AXI traffic.
//   AXI_BURST_INCR / AXI_LEN_SINGLE : fixed single-beat INCR burst fields
//   AXI_RESP_OKAY                   : response code driven after reset
//   rw_state_t                      : bridge FSM state encoding
//   axi_size()                      : maps log2-bytes request size onto AxSIZE
package ysyx_2022040010_axi_rw_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW_W = 3'd3,
      ST_B    = 3'd4,
      ST_DONE = 3'd5
   } rw_state_t;

   function automatic logic [2:0] axi_size(input logic [1:0] size);
      return {1'b0, size};
   endfunction

endpackage

// File: rtl/ysyx_2022040010_axi_rw.sv
// rtl/ysyx_2022040010_axi_rw.sv - single-outstanding AXI4 read/write bridge for the cache arbiter
// Purpose: turns one arbiter request (read or write, 1..8 bytes) into a single-beat
// AXI4 transaction and reports completion with a one-cycle rw_ready_o pulse.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   rw_valid_i .. rw_data_i    : request from arbiter (req 0=read/1=write, addr, size, id, mask, data)
//   rw_ready_o, rw_data_o,
//   rw_id_o, rw_resp_o         : completion pulse with read data, ID and AXI response
//   aw_* / w_* / b_*           : AXI write address, write data and write response channels
//   ar_* / r_*                 : AXI read address and read data channels
module ysyx_2022040010_axi_rw
   import ysyx_2022040010_axi_rw_pkg::*;
#(
   parameter int RW_ID_W = 4,
   parameter int ADDR_W  = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rw_valid_i,
   input  logic               rw_req_i,
   input  logic [ADDR_W-1:0]  rw_addr_i,
   input  logic [1:0]         rw_size_i,
   input  logic [RW_ID_W-1:0] rw_id_i,
   input  logic [7:0]         rw_mask_i,
   input  logic [63:0]        rw_data_i,
   output logic               rw_ready_o,
   output logic [63:0]        rw_data_o,
   output logic [RW_ID_W-1:0] rw_id_o,
   output logic [1:0]         rw_resp_o,
   output logic               aw_valid_o,
   input  logic               aw_ready_i,
   output logic [ADDR_W-1:0]  aw_addr_o,
   output logic [RW_ID_W-1:0] aw_id_o,
   output logic [7:0]         aw_len_o,
   output logic [2:0]         aw_size_o,
   output logic [1:0]         aw_burst_o,
   output logic               w_valid_o,
   input  logic               w_ready_i,
   output logic [63:0]        w_data_o,
   output logic [7:0]         w_strb_o,
   output logic               w_last_o,
   input  logic               b_valid_i,
   output logic               b_ready_o,
   input  logic [1:0]         b_resp_i,
   input  logic [RW_ID_W-1:0] b_id_i,
   output logic               ar_valid_o,
   input  logic               ar_ready_i,
   output logic [ADDR_W-1:0]  ar_addr_o,
   output logic [RW_ID_W-1:0] ar_id_o,
   output logic [7:0]         ar_len_o,
   output logic [2:0]         ar_size_o,
   output logic [1:0]         ar_burst_o,
   input  logic               r_valid_i,
   output logic               r_ready_o,
   input  logic [63:0]        r_data_i,
   input  logic [1:0]         r_resp_i,
   input  logic               r_last_i,
   input  logic [RW_ID_W-1:0] r_id_i
);

   rw_state_t          r_state;
   logic [ADDR_W-1:0]  r_addr;
   logic [1:0]         r_size;
   logic [RW_ID_W-1:0] r_id;
   logic [7:0]         r_mask;
   logic [63:0]        r_wdata;
   logic               r_aw_done;
   logic               r_w_done;

   logic w_aw_hs;
   logic w_w_hs;

   // Only one transaction is ever in flight, so beat/ID tags carry no information.
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, r_last_i, r_id_i, b_id_i};

   assign w_aw_hs = aw_valid_o & aw_ready_i;
   assign w_w_hs  = w_valid_o & w_ready_i;

   // Payload comes straight from the request registers, which only change in IDLE,
   // so it is stable for the whole life of each valid.
   assign aw_addr_o  = r_addr;
   assign aw_id_o    = r_id;
   assign aw_len_o   = AXI_LEN_SINGLE;
   assign aw_size_o  = axi_size(r_size);
   assign aw_burst_o = AXI_BURST_INCR;
   assign w_data_o   = r_wdata;
   assign w_strb_o   = r_mask;
   assign w_last_o   = 1'b1;
   assign ar_addr_o  = r_addr;
   assign ar_id_o    = r_id;
   assign ar_len_o   = AXI_LEN_SINGLE;
   assign ar_size_o  = axi_size(r_size);
   assign ar_burst_o = AXI_BURST_INCR;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_size     <= '0;
         r_id       <= '0;
         r_mask     <= '0;
         r_wdata    <= '0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
         aw_valid_o <= 1'b0;
         w_valid_o  <= 1'b0;
         b_ready_o  <= 1'b0;
         ar_valid_o <= 1'b0;
         r_ready_o  <= 1'b0;
         rw_ready_o <= 1'b0;
         rw_data_o  <= '0;
         rw_id_o    <= '0;
         rw_resp_o  <= AXI_RESP_OKAY;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (rw_valid_i) begin
                  r_addr  <= rw_addr_i;
                  r_size  <= rw_size_i;
                  r_id    <= rw_id_i;
                  r_mask  <= rw_mask_i;
                  r_wdata <= rw_data_i;
                  if (rw_req_i) begin
                     aw_valid_o <= 1'b1;
                     w_valid_o  <= 1'b1;
                     r_state    <= ST_AW_W;
                  end else begin
                     ar_valid_o <= 1'b1;
                     r_state    <= ST_AR;
                  end
               end
            end
            ST_AR: begin
               if (ar_ready_i) begin
                  ar_valid_o <= 1'b0;
                  r_ready_o  <= 1'b1;
                  r_state    <= ST_R;
               end
            end
            ST_R: begin
               if (r_valid_i) begin
                  r_ready_o  <= 1'b0;
                  rw_data_o  <= r_data_i;
                  rw_resp_o  <= r_resp_i;
                  rw_id_o    <= r_id;
                  rw_ready_o <= 1'b1;
                  r_state    <= ST_DONE;
               end
            end
            ST_AW_W: begin
               if (w_aw_hs) begin
                  aw_valid_o <= 1'b0;
                  r_aw_done  <= 1'b1;
               end
               if (w_w_hs) begin
                  w_valid_o <= 1'b0;
                  r_w_done  <= 1'b1;
               end
               // Either handshake may land this cycle or have landed earlier.
               if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  b_ready_o <= 1'b1;
                  r_state   <= ST_B;
               end
            end
            ST_B: begin
               if (b_valid_i) begin
                  b_ready_o  <= 1'b0;
                  rw_data_o  <= '0;
                  rw_resp_o  <= b_resp_i;
                  rw_id_o    <= r_id;
                  rw_ready_o <= 1'b1;
                  r_state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               // rw_valid_i is still high here from the finished request; ignore it.
               rw_ready_o <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_2022040010_axi_rw.sv
// tb/tb_ysyx_2022040010_axi_rw.sv - self-checking bench for the AXI read/write bridge
module tb_ysyx_2022040010_axi_rw;

   logic        clk = 1'b0;
   logic        rst;
   logic        rw_valid_i, rw_req_i;
   logic [63:0] rw_addr_i;
   logic [1:0]  rw_size_i;
   logic [3:0]  rw_id_i;
   logic [7:0]  rw_mask_i;
   logic [63:0] rw_data_i;
   logic        rw_ready_o;
   logic [63:0] rw_data_o;
   logic [3:0]  rw_id_o;
   logic [1:0]  rw_resp_o;
   logic        aw_valid_o, aw_ready_i;
   logic [63:0] aw_addr_o;
   logic [3:0]  aw_id_o;
   logic [7:0]  aw_len_o;
   logic [2:0]  aw_size_o;
   logic [1:0]  aw_burst_o;
   logic        w_valid_o, w_ready_i;
   logic [63:0] w_data_o;
   logic [7:0]  w_strb_o;
   logic        w_last_o;
   logic        b_valid_i, b_ready_o;
   logic [1:0]  b_resp_i;
   logic [3:0]  b_id_i;
   logic        ar_valid_o, ar_ready_i;
   logic [63:0] ar_addr_o;
   logic [3:0]  ar_id_o;
   logic [7:0]  ar_len_o;
   logic [2:0]  ar_size_o;
   logic [1:0]  ar_burst_o;
   logic        r_valid_i, r_ready_o;
   logic [63:0] r_data_i;
   logic [1:0]  r_resp_i;
   logic        r_last_i;
   logic [3:0]  r_id_i;

   always #5 clk = ~clk;

   ysyx_2022040010_axi_rw #(.RW_ID_W(4), .ADDR_W(64)) dut (
      .clk(clk), .rst(rst),
      .rw_valid_i(rw_valid_i), .rw_req_i(rw_req_i), .rw_addr_i(rw_addr_i),
      .rw_size_i(rw_size_i), .rw_id_i(rw_id_i), .rw_mask_i(rw_mask_i), .rw_data_i(rw_data_i),
      .rw_ready_o(rw_ready_o), .rw_data_o(rw_data_o), .rw_id_o(rw_id_o), .rw_resp_o(rw_resp_o),
      .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_id_o(aw_id_o),
      .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
      .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
      .w_last_o(w_last_o),
      .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i), .b_id_i(b_id_i),
      .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_id_o(ar_id_o),
      .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
      .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
      .r_last_i(r_last_i), .r_id_i(r_id_i)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Observations of the last transaction
   int          got_cnt, got_lat;
   logic [63:0] got_data;
   logic [3:0]  got_id;
   logic [1:0]  got_resp;
   int          ar_hs, aw_hs, w_hs, r_hs, b_hs, aw_cyc, w_cyc, pay_err;

   task automatic slave_quiet();
      aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_resp_i = 0; b_id_i = 0;
      ar_ready_i = 0; r_valid_i = 0; r_data_i = 0; r_resp_i = 0; r_last_i = 0; r_id_i = 0;
   endtask

   // Issue one request and act as an AXI slave with given per-channel wait counts.
   // Cycle 1 is the cycle after the acceptance edge.
   task automatic run_txn(input bit wr, input logic [63:0] addr, input logic [1:0] size,
                          input logic [3:0] id, input logic [7:0] mask, input logic [63:0] wdata,
                          input logic [63:0] rdata, input logic [1:0] resp,
                          input int a_dly, input int w_dly, input int s_dly);
      int ar_seen, aw_seen, w_seen, r_seen, b_seen, ready_cyc;
      ar_seen = 0; aw_seen = 0; w_seen = 0; r_seen = 0; b_seen = 0; ready_cyc = -1;
      got_cnt = 0; got_lat = -1; got_data = '0; got_id = '0; got_resp = '0;
      ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0; aw_cyc = 0; w_cyc = 0; pay_err = 0;
      @(negedge clk);
      rw_valid_i = 1; rw_req_i = wr; rw_addr_i = addr; rw_size_i = size;
      rw_id_i = id; rw_mask_i = mask; rw_data_i = wdata;
      @(posedge clk);
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         // Requester drops its request the cycle after seeing the completion pulse.
         if (ready_cyc >= 0 && cyc == ready_cyc + 1) rw_valid_i = 0;
         r_id_i = 4'($urandom); b_id_i = 4'($urandom); r_last_i = 1'($urandom);
         if (ar_valid_o === 1'b1) begin
            if (ar_addr_o !== addr || ar_size_o !== {1'b0, size} || ar_len_o !== 8'd0 ||
                ar_burst_o !== 2'b01 || ar_id_o !== id) pay_err++;
            ar_ready_i = (ar_seen >= a_dly);
            if (ar_ready_i) ar_hs++;
            ar_seen++;
         end else ar_ready_i = 0;
         if (aw_valid_o === 1'b1) begin
            if (aw_addr_o !== addr || aw_size_o !== {1'b0, size} || aw_len_o !== 8'd0 ||
                aw_burst_o !== 2'b01 || aw_id_o !== id) pay_err++;
            aw_ready_i = (aw_seen >= a_dly);
            if (aw_ready_i) aw_hs++;
            aw_seen++; aw_cyc++;
         end else aw_ready_i = 0;
         if (w_valid_o === 1'b1) begin
            if (w_data_o !== wdata || w_strb_o !== mask || w_last_o !== 1'b1) pay_err++;
            w_ready_i = (w_seen >= w_dly);
            if (w_ready_i) w_hs++;
            w_seen++; w_cyc++;
         end else w_ready_i = 0;
         if (r_ready_o === 1'b1) begin
            r_valid_i = (r_seen >= s_dly);
            r_data_i  = r_valid_i ? rdata : {$urandom, $urandom};
            r_resp_i  = resp;
            if (r_valid_i) r_hs++;
            r_seen++;
         end else begin
            r_valid_i = 0; r_data_i = {$urandom, $urandom}; r_resp_i = 2'($urandom);
         end
         if (b_ready_o === 1'b1) begin
            b_valid_i = (b_seen >= s_dly);
            b_resp_i  = resp;
            if (b_valid_i) b_hs++;
            b_seen++;
         end else begin
            b_valid_i = 0; b_resp_i = 2'($urandom);
         end
         if (rw_ready_o === 1'b1) begin
            got_cnt++;
            if (ready_cyc < 0) begin
               ready_cyc = cyc; got_lat = cyc;
               got_data = rw_data_o; got_id = rw_id_o; got_resp = rw_resp_o;
            end
         end
         if (ready_cyc >= 0 && cyc >= ready_cyc + 4) break;
      end
      slave_quiet();
      rw_valid_i = 0;
   endtask

   task automatic test_reset();
      rst = 1; rw_valid_i = 1; rw_req_i = 0; slave_quiet();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({rw_ready_o, ar_valid_o, aw_valid_o, w_valid_o, r_ready_o, b_ready_o} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_valids: got %b expected 000000",
                  {rw_ready_o, ar_valid_o, aw_valid_o, w_valid_o, r_ready_o, b_ready_o});
      end
      n_tests++;
      if ({rw_data_o, rw_id_o, rw_resp_o} !== 70'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%h id=%h resp=%h expected all 0",
                  rw_data_o, rw_id_o, rw_resp_o);
      end
      rw_valid_i = 0; rst = 0;
      @(negedge clk);
   endtask

   task automatic test_read_zero_wait();
      run_txn(0, 64'h8000_0008, 2'd3, 4'd0, 8'hFF, 64'h0, 64'hDEAD_BEEF_0123_4567, 2'b00, 0, 0, 0);
      n_tests++;
      if (got_lat !== 3) begin n_fail++; $display("FAIL rd0_latency: got %0d expected 3", got_lat); end
      n_tests++;
      if (got_data !== 64'hDEAD_BEEF_0123_4567 || got_id !== 4'd0) begin
         n_fail++;
         $display("FAIL rd0_data: got %h id %0d expected deadbeef01234567 id 0", got_data, got_id);
      end
      n_tests++;
      if (pay_err !== 0) begin n_fail++; $display("FAIL rd0_ar_payload: got %0d errors expected 0", pay_err); end
      n_tests++;
      if (got_cnt !== 1 || ar_hs !== 1 || aw_hs !== 0) begin
         n_fail++;
         $display("FAIL rd0_counts: got ready=%0d ar=%0d aw=%0d expected 1 1 0", got_cnt, ar_hs, aw_hs);
      end
   endtask

   task automatic test_write_aw_late();
      run_txn(1, 64'h8000_1000, 2'd3, 4'd1, 8'h0F, 64'h1122_3344_5566_7788, 64'h0, 2'b00, 3, 0, 0);
      n_tests++;
      if (w_cyc !== 1 || aw_cyc !== 4) begin
         n_fail++;
         $display("FAIL wr_late_valid_cycles: got w=%0d aw=%0d expected w=1 aw=4", w_cyc, aw_cyc);
      end
      n_tests++;
      if (got_cnt !== 1 || got_lat !== 6) begin
         n_fail++;
         $display("FAIL wr_late_done: got pulses=%0d lat=%0d expected 1 6", got_cnt, got_lat);
      end
      n_tests++;
      if (got_data !== 64'h0 || got_id !== 4'd1 || got_resp !== 2'b00 || pay_err !== 0) begin
         n_fail++;
         $display("FAIL wr_late_result: got data=%h id=%0d resp=%0d perr=%0d expected 0 1 0 0",
                  got_data, got_id, got_resp, pay_err);
      end
   endtask

   task automatic test_write_same_cycle();
      run_txn(1, 64'h8000_2004, 2'd2, 4'd2, 8'h0F, 64'hCAFE_F00D_1234_5678, 64'h0, 2'b11, 0, 0, 0);
      n_tests++;
      if (got_lat !== 3 || got_cnt !== 1) begin
         n_fail++;
         $display("FAIL wr_same_latency: got lat=%0d pulses=%0d expected 3 1", got_lat, got_cnt);
      end
      n_tests++;
      if (pay_err !== 0 || got_resp !== 2'b11) begin
         n_fail++;
         $display("FAIL wr_same_strb_resp: got perr=%0d resp=%0d expected 0 3", pay_err, got_resp);
      end
   endtask

   task automatic test_read_error();
      run_txn(0, 64'h8000_3000, 2'd1, 4'd2, 8'h00, 64'h0, 64'h0000_0000_0000_BEEF, 2'b10, 1, 0, 2);
      n_tests++;
      if (got_resp !== 2'b10 || got_cnt !== 1 || got_lat !== 6) begin
         n_fail++;
         $display("FAIL rd_err: got resp=%0d pulses=%0d lat=%0d expected 2 1 6", got_resp, got_cnt, got_lat);
      end
      run_txn(0, 64'h8000_3008, 2'd3, 4'd0, 8'h00, 64'h0, 64'h0123_0000_0000_0001, 2'b00, 0, 0, 0);
      n_tests++;
      if (got_lat !== 3 || got_resp !== 2'b00) begin
         n_fail++;
         $display("FAIL rd_err_recover: got lat=%0d resp=%0d expected 3 0", got_lat, got_resp);
      end
   endtask

   task automatic test_back_to_back();
      run_txn(0, 64'h8000_4000, 2'd3, 4'd1, 8'h00, 64'h0, 64'h5555_AAAA_5555_AAAA, 2'b00, 0, 0, 0);
      n_tests++;
      if (ar_hs !== 1 || got_cnt !== 1) begin
         n_fail++;
         $display("FAIL b2b_read_once: got ar=%0d pulses=%0d expected 1 1", ar_hs, got_cnt);
      end
      run_txn(1, 64'h8000_4008, 2'd3, 4'd1, 8'hFF, 64'h7777_8888_9999_0000, 64'h0, 2'b00, 0, 0, 0);
      n_tests++;
      if (aw_hs !== 1 || w_hs !== 1 || b_hs !== 1 || got_cnt !== 1) begin
         n_fail++;
         $display("FAIL b2b_write_once: got aw=%0d w=%0d b=%0d pulses=%0d expected 1 1 1 1",
                  aw_hs, w_hs, b_hs, got_cnt);
      end
   endtask

   task automatic test_reset_in_r();
      int seen_r, pulses;
      seen_r = 0; pulses = 0;
      @(negedge clk);
      rw_valid_i = 1; rw_req_i = 0; rw_addr_i = 64'h8000_5000; rw_size_i = 3; rw_id_i = 2;
      ar_ready_i = 1; r_valid_i = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (r_ready_o === 1'b1) begin seen_r = 1; break; end
      end
      n_tests++;
      if (seen_r !== 1) begin n_fail++; $display("FAIL rst_in_r_reach: got %0d expected 1", seen_r); end
      rst = 1; rw_valid_i = 0; ar_ready_i = 0;
      @(negedge clk);
      n_tests++;
      if ({r_ready_o, rw_ready_o, ar_valid_o} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_in_r_outputs: got %b expected 000", {r_ready_o, rw_ready_o, ar_valid_o});
      end
      rst = 0; r_valid_i = 1; r_data_i = 64'h1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rw_ready_o === 1'b1 || r_ready_o === 1'b1) pulses++;
      end
      slave_quiet();
      n_tests++;
      if (pulses !== 0) begin n_fail++; $display("FAIL rst_in_r_no_pulse: got %0d expected 0", pulses); end
      run_txn(0, 64'h8000_5008, 2'd3, 4'd0, 8'h00, 64'h0, 64'h0F0F_0F0F_F0F0_F0F0, 2'b00, 0, 0, 0);
      n_tests++;
      if (got_lat !== 3 || got_data !== 64'h0F0F_0F0F_F0F0_F0F0) begin
         n_fail++;
         $display("FAIL rst_in_r_idle: got lat=%0d data=%h expected 3 0f0f0f0ff0f0f0f0", got_lat, got_data);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 30; k++) begin
         bit          wr;
         logic [63:0] addr, wd, rd, exp_data;
         logic [1:0]  size, resp;
         logic [3:0]  id;
         logic [7:0]  mask;
         int          a, w, s, exp_lat, hs_code, exp_code;
         wr = 1'($urandom); addr = {$urandom, $urandom}; wd = {$urandom, $urandom};
         rd = {$urandom, $urandom}; size = 2'($urandom); resp = 2'($urandom);
         id = 4'($urandom_range(2, 0)); mask = 8'($urandom);
         a = $urandom_range(3, 0); w = $urandom_range(3, 0); s = $urandom_range(3, 0);
         run_txn(wr, addr, size, id, mask, wd, rd, resp, a, w, s);
         exp_lat  = wr ? 3 + ((a > w) ? a : w) + s : 3 + a + s;
         exp_data = wr ? 64'h0 : rd;
         exp_code = wr ? 1101 : 10010;
         hs_code  = ar_hs * 10000 + aw_hs * 1000 + w_hs * 100 + r_hs * 10 + b_hs;
         n_tests++;
         if (got_cnt !== 1 || got_lat !== exp_lat) begin
            n_fail++;
            $display("FAIL rand%0d_timing: got pulses=%0d lat=%0d expected 1 %0d", k, got_cnt, got_lat, exp_lat);
         end
         n_tests++;
         if (got_data !== exp_data || got_id !== id || got_resp !== resp) begin
            n_fail++;
            $display("FAIL rand%0d_result: got %h/%0d/%0d expected %h/%0d/%0d",
                     k, got_data, got_id, got_resp, exp_data, id, resp);
         end
         n_tests++;
         if (pay_err !== 0 || hs_code !== exp_code) begin
            n_fail++;
            $display("FAIL rand%0d_channels: got perr=%0d hs=%0d expected 0 %0d", k, pay_err, hs_code, exp_code);
         end
         if (wr) begin
            n_tests++;
            if (aw_cyc !== a + 1 || w_cyc !== w + 1) begin
               n_fail++;
               $display("FAIL rand%0d_valid_drop: got aw=%0d w=%0d expected %0d %0d", k, aw_cyc, w_cyc, a + 1, w + 1);
            end
         end
      end
   endtask

   initial begin
      rst = 1; rw_valid_i = 0; rw_req_i = 0; rw_addr_i = 0; rw_size_i = 0;
      rw_id_i = 0; rw_mask_i = 0; rw_data_i = 0;
      slave_quiet();
      test_reset();
      test_read_zero_wait();
      test_write_aw_late();
      test_write_same_cycle();
      test_read_error();
      test_back_to_back();
      test_reset_in_r();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
